// File: rtl/pkt_fifo.sv
// rtl/pkt_fifo.sv - packet-aware store-and-forward FIFO with atomic drop of overflowing or abandoned packets
module pkt_fifo #(
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH_LOG2 = 5,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_sop,
    input  logic                  wr_eop,
    input  logic                  wr_vld,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic                  rd_vld,
    output logic                  rd_sop,
    output logic                  rd_eop,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic [DEPTH_LOG2:0]   pkt_cnt,
    output logic [DEPTH_LOG2:0]   free_cnt,
    output logic                  overflow,
    output logic [CNT_WIDTH-1:0]  drop_cnt
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int PW    = DEPTH_LOG2 + 1;
    localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);

    typedef enum logic [1:0] {ST_IDLE, ST_RECV, ST_DROP} state_t;

    logic [DATA_WIDTH+1:0] r_mem [DEPTH];
    logic [PW-1:0]         r_rptr;
    logic [PW-1:0]         r_wptr_spec;
    logic [PW-1:0]         r_wptr_cmt;
    logic [PW-1:0]         r_pkt_cnt;
    state_t                r_state;
    logic                  r_overflow;
    logic [CNT_WIDTH-1:0]  r_drop_cnt;

    logic                  w_start;
    logic                  w_abandon;
    logic                  w_cont;
    logic                  w_accept;
    logic [PW-1:0]         w_base;
    logic                  w_full;
    logic                  w_store;
    logic                  w_ovf;
    logic                  w_commit;
    logic                  w_pop;
    logic                  w_pop_eop;
    logic [DATA_WIDTH+1:0] w_head;
    logic [CNT_WIDTH:0]    w_drop_sum;

    assign w_start   = wr_vld & wr_sop;
    assign w_abandon = (r_state == ST_RECV) & w_start;
    assign w_cont    = (r_state == ST_RECV) & wr_vld & ~wr_sop;
    assign w_accept  = w_start | w_cont;
    // An abandoning sop restarts at the commit pointer, so fullness is judged from there.
    assign w_base    = w_abandon ? r_wptr_cmt : r_wptr_spec;
    assign w_full    = (w_base - r_rptr) == DEPTH_P;
    assign w_store   = w_accept & ~w_full;
    assign w_ovf     = w_accept & w_full;
    assign w_commit  = w_store & wr_eop;

    assign w_head    = r_mem[r_rptr[DEPTH_LOG2-1:0]];
    assign rd_vld    = (r_pkt_cnt != '0);
    assign rd_sop    = w_head[DATA_WIDTH+1];
    assign rd_eop    = w_head[DATA_WIDTH];
    assign rd_data   = w_head[DATA_WIDTH-1:0];
    assign w_pop     = rd_en & rd_vld;
    assign w_pop_eop = w_pop & w_head[DATA_WIDTH];

    assign w_drop_sum = {1'b0, r_drop_cnt} + {{CNT_WIDTH{1'b0}}, w_abandon}
                      + {{CNT_WIDTH{1'b0}}, w_ovf};

    assign pkt_cnt  = r_pkt_cnt;
    assign free_cnt = DEPTH_P - (r_wptr_spec - r_rptr);
    assign overflow = r_overflow;
    assign drop_cnt = r_drop_cnt;

    always_ff @(posedge clk) begin
        if (w_store) begin
            r_mem[w_base[DEPTH_LOG2-1:0]] <= {wr_sop, wr_eop, wr_data};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rptr      <= '0;
            r_wptr_spec <= '0;
            r_wptr_cmt  <= '0;
            r_pkt_cnt   <= '0;
            r_state     <= ST_IDLE;
            r_overflow  <= 1'b0;
            r_drop_cnt  <= '0;
        end else begin
            if (w_store) begin
                r_wptr_spec <= w_base + 1'b1;
            end else if (w_ovf) begin
                r_wptr_spec <= r_wptr_cmt;
            end
            if (w_commit) begin
                r_wptr_cmt <= w_base + 1'b1;
            end

            if (w_ovf) begin
                r_state <= wr_eop ? ST_IDLE : ST_DROP;
            end else if (w_store) begin
                r_state <= wr_eop ? ST_IDLE : ST_RECV;
            end else if (r_state == ST_DROP && wr_vld && wr_eop) begin
                r_state <= ST_IDLE;
            end

            if (w_commit && !w_pop_eop) begin
                r_pkt_cnt <= r_pkt_cnt + 1'b1;
            end else if (!w_commit && w_pop_eop) begin
                r_pkt_cnt <= r_pkt_cnt - 1'b1;
            end

            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end

            r_overflow <= r_overflow | w_ovf;
            r_drop_cnt <= w_drop_sum[CNT_WIDTH] ? {CNT_WIDTH{1'b1}} : w_drop_sum[CNT_WIDTH-1:0];
        end
    end
endmodule

// File: tb/tb_pkt_fifo.sv
// tb/tb_pkt_fifo.sv - directed bench for pkt_fifo against a queue-based packet model
module tb_pkt_fifo;
    localparam int DW    = 64;
    localparam int DL    = 5;
    localparam int CW    = 8;
    localparam int DEPTH = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr_sop = 1'b0, wr_eop = 1'b0, wr_vld = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic          rd_en = 1'b0;
    logic          rd_vld, rd_sop, rd_eop;
    logic [DW-1:0] rd_data;
    logic [DL:0]   pkt_cnt, free_cnt;
    logic          overflow;
    logic [CW-1:0] drop_cnt;

    pkt_fifo #(.DATA_WIDTH(DW), .DEPTH_LOG2(DL), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst),
        .wr_sop(wr_sop), .wr_eop(wr_eop), .wr_vld(wr_vld), .wr_data(wr_data),
        .rd_en(rd_en), .rd_vld(rd_vld), .rd_sop(rd_sop), .rd_eop(rd_eop),
        .rd_data(rd_data), .pkt_cnt(pkt_cnt), .free_cnt(free_cnt),
        .overflow(overflow), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    // Model: committed words are readable, partial words only occupy space.
    logic [DW+1:0] m_cmt[$];
    logic [DW+1:0] m_part[$];
    int            m_state = 0;
    bit            m_ovf = 1'b0;
    int            m_drop = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic int m_pkts();
        int n = 0;
        foreach (m_cmt[i]) if (m_cmt[i][DW]) n++;
        return n;
    endfunction

    task automatic m_drop_one();
        if (m_drop < 255) m_drop++;
    endtask

    task automatic m_overflow();
        m_part.delete();
        m_ovf = 1'b1;
        m_drop_one();
        m_state = wr_eop ? 0 : 2;
    endtask

    task automatic m_store(input logic sop);
        m_part.push_back({sop, wr_eop, wr_data});
        if (wr_eop) begin
            foreach (m_part[i]) m_cmt.push_back(m_part[i]);
            m_part.delete();
            m_state = 0;
        end else begin
            m_state = 1;
        end
    endtask

    task automatic model_step();
        int occ_all;
        int occ_cmt;
        int occ;
        if (rst) begin
            m_cmt.delete(); m_part.delete();
            m_state = 0; m_ovf = 1'b0; m_drop = 0;
            return;
        end
        occ_all = m_cmt.size() + m_part.size();
        occ_cmt = m_cmt.size();
        if (rd_en && m_cmt.size() > 0) void'(m_cmt.pop_front());
        if (wr_vld && wr_sop) begin
            occ = occ_all;
            if (m_state == 1) begin
                m_part.delete();
                m_drop_one();
                occ = occ_cmt;
            end
            if (occ == DEPTH) m_overflow();
            else m_store(1'b1);
        end else if (wr_vld && m_state == 1) begin
            if (occ_all == DEPTH) m_overflow();
            else m_store(1'b0);
        end else if (wr_vld && m_state == 2 && wr_eop) begin
            m_state = 0;
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("rd_vld", {63'd0, rd_vld}, {63'd0, m_cmt.size() > 0});
            check("pkt_cnt", 64'(pkt_cnt), 64'(m_pkts()));
            check("free_cnt", 64'(free_cnt), 64'(DEPTH - m_cmt.size() - m_part.size()));
            check("overflow", {63'd0, overflow}, {63'd0, m_ovf});
            check("drop_cnt", 64'(drop_cnt), 64'(m_drop));
            if (m_cmt.size() > 0) begin
                check("rd_sop", {63'd0, rd_sop}, {63'd0, m_cmt[0][DW+1]});
                check("rd_eop", {63'd0, rd_eop}, {63'd0, m_cmt[0][DW]});
                check("rd_data", rd_data, m_cmt[0][DW-1:0]);
            end
        end
    end

    task automatic cyc(input logic vld, input logic sop, input logic eop,
                       input logic [63:0] d, input logic rden);
        wr_vld = vld; wr_sop = sop; wr_eop = eop; wr_data = d; rd_en = rden;
        @(posedge clk);
        model_step();
        #1;
        wr_vld = 1'b0; wr_sop = 1'b0; wr_eop = 1'b0; rd_en = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, 64'd0, 1'b0);
        rst = 1'b0;
    endtask

    task automatic write_pkt(input int len, input logic [63:0] base);
        for (int i = 0; i < len; i++)
            cyc(1'b1, i == 0, i == len - 1, base + 64'(i), 1'b0);
    endtask

    task automatic read_n(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 64'd0, 1'b1);
    endtask

    initial begin
        do_reset();
        chk_en = 1'b1;
        check("reset_free", 64'(free_cnt), 64'd32);
        check("reset_vld", {63'd0, rd_vld}, 64'd0);

        // 4-word packet: visible only after the eop cycle
        for (int i = 0; i < 3; i++) cyc(1'b1, i == 0, 1'b0, 64'h10 + 64'(i), 1'b0);
        check("vld_before_eop", {63'd0, rd_vld}, 64'd0);
        cyc(1'b1, 1'b0, 1'b1, 64'h13, 1'b0);
        check("vld_after_eop", {63'd0, rd_vld}, 64'd1);
        check("pkt1", 64'(pkt_cnt), 64'd1);
        for (int i = 0; i < 4; i++) begin
            check("t1_data", rd_data, 64'h10 + 64'(i));
            check("t1_sop", {63'd0, rd_sop}, {63'd0, i == 0});
            check("t1_eop", {63'd0, rd_eop}, {63'd0, i == 3});
            cyc(1'b0, 1'b0, 1'b0, 64'd0, 1'b1);
        end
        check("t1_pkt0", 64'(pkt_cnt), 64'd0);
        check("t1_free", 64'(free_cnt), 64'd32);

        // single-word packet
        cyc(1'b1, 1'b1, 1'b1, 64'hAB, 1'b0);
        check("t2_pkt", 64'(pkt_cnt), 64'd1);
        check("t2_sop", {63'd0, rd_sop}, 64'd1);
        check("t2_eop", {63'd0, rd_eop}, 64'd1);
        check("t2_data", rd_data, 64'hAB);
        read_n(1);

        // overflow: 20 + 16 words into 32 entries
        write_pkt(20, 64'h100);
        for (int i = 0; i < 13; i++) cyc(1'b1, i == 0, 1'b0, 64'h200 + 64'(i), 1'b0);
        check("t3_drop", 64'(drop_cnt), 64'd1);
        check("t3_ovf", {63'd0, overflow}, 64'd1);
        check("t3_pkt", 64'(pkt_cnt), 64'd1);
        check("t3_free", 64'(free_cnt), 64'd12);
        for (int i = 13; i < 16; i++) cyc(1'b1, 1'b0, i == 15, 64'h200 + 64'(i), 1'b0);
        check("t3_head", rd_data, 64'h100);
        read_n(20);
        write_pkt(10, 64'h300);
        check("t3_pkt10", 64'(pkt_cnt), 64'd1);
        check("t3_head10", rd_data, 64'h300);
        read_n(10);

        // wrap-around
        do_reset();
        for (int p = 0; p < 5; p++) begin
            write_pkt(24, 64'h1000 + 64'(p * 24));
            read_n(24);
        end
        check("t4_drop", 64'(drop_cnt), 64'd0);
        check("t4_free", 64'(free_cnt), 64'd32);

        // eop pop coincides with commit
        write_pkt(2, 64'hA0);
        cyc(1'b1, 1'b1, 1'b0, 64'hB0, 1'b1);
        cyc(1'b1, 1'b0, 1'b1, 64'hB1, 1'b1);
        check("t5_pkt", 64'(pkt_cnt), 64'd1);
        check("t5_head", rd_data, 64'hB0);
        read_n(2);

        // abandoned partial packet
        do_reset();
        for (int i = 0; i < 3; i++) cyc(1'b1, i == 0, 1'b0, 64'hC0 + 64'(i), 1'b0);
        write_pkt(2, 64'hD0);
        check("t6_drop", 64'(drop_cnt), 64'd1);
        check("t6_ovf", {63'd0, overflow}, 64'd0);
        check("t6_pkt", 64'(pkt_cnt), 64'd1);
        check("t6_head", rd_data, 64'hD0);
        read_n(2);

        // reset mid-packet
        write_pkt(1, 64'hE0);
        cyc(1'b1, 1'b1, 1'b0, 64'hF0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 64'hF1, 1'b0);
        do_reset();
        check("t7_vld", {63'd0, rd_vld}, 64'd0);
        check("t7_pkt", 64'(pkt_cnt), 64'd0);
        check("t7_free", 64'(free_cnt), 64'd32);
        cyc(1'b0, 1'b0, 1'b0, 64'd0, 1'b0);

        @(negedge clk);
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/pkt_fifo.md
Name: pkt_fifo

Overview:
- Single-clock, parametrised, packet-aware store-and-forward FIFO; next generation of the per-priority ingress buffer in front of the SRAM controller.
- Accepts sop/eop/vld-framed words, exposes a packet to the reader only once its eop word is stored, and drops a whole packet atomically on overflow or on a malformed frame.
- Intended to be instantiated once per priority queue.

Parameters:
- DATA_WIDTH, 64, payload bits per word.
- DEPTH_LOG2, 5, log2 of storage depth (DEPTH = 2**DEPTH_LOG2 words).
- CNT_WIDTH, 8, width of the saturating drop counter.

Ports:
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- wr_sop  in  1  first word of packet (qualified by wr_vld).
- wr_eop  in  1  last word of packet (qualified by wr_vld).
- wr_vld  in  1  wr_data valid this cycle; no backpressure.
- wr_data  in  DATA_WIDTH  write payload.
- rd_en  in  1  pop current head word (qualified by rd_vld).
- rd_vld  out  1  a head word of a committed packet is presented.
- rd_sop  out  1  head word is first of its packet.
- rd_eop  out  1  head word is last of its packet.
- rd_data  out  DATA_WIDTH  head word payload (first-word fall-through).
- pkt_cnt  out  DEPTH_LOG2+1  committed, not fully read packets.
- free_cnt  out  DEPTH_LOG2+1  DEPTH minus (speculative write ptr minus read ptr).
- overflow  out  1  sticky: a packet was dropped for lack of space.
- drop_cnt  out  CNT_WIDTH  packets dropped (overflow or abandoned), saturating.

Behaviour:
- Clocking/reset: one clock, clk; reset rst is synchronous and active-high.
- Storage: DEPTH entries of {sop, eop, data}; memory contents are not reset.
- Pointers: DEPTH_LOG2+1 bits with wrap bit, named rptr, wptr_spec, wptr_cmt.
- Reset: all pointers 0, state IDLE, pkt_cnt=0, free_cnt=DEPTH, overflow=0, drop_cnt=0, rd_vld=0. Reset mid-packet discards all stored and partial data.
- Full: (wptr_spec - rptr) == DEPTH, evaluated on registered values at start of cycle; a same-cycle pop does not free space for a same-cycle write.
- Write FSM, IDLE:
  - wr_vld&wr_sop: store word at wptr_spec, wptr_spec++.
  - If wr_eop is also set, commit (wptr_cmt <= wptr_spec+1, pkt_cnt++) and stay IDLE; otherwise go to RECV.
  - wr_vld without wr_sop is ignored.
- Write FSM, RECV:
  - wr_vld&!wr_sop: store word, wptr_spec++.
  - wr_eop on that word: commit, go to IDLE.
  - wr_vld&wr_sop: abandon the partial packet (wptr_spec <= wptr_cmt), drop_cnt++, overflow unchanged; the sop word starts a new packet at wptr_cmt, with the IDLE rules applied.
- Write FSM, full on write: when an accepted word arrives while full, in IDLE or RECV:
  - Word is not stored; wptr_spec <= wptr_cmt (rollback); overflow <= 1; drop_cnt++.
  - Next state: IDLE if the word had eop, else DROP.
- Write FSM, DROP:
  - Discard words until wr_vld&wr_eop, then go to IDLE.
  - wr_vld&wr_sop in DROP is handled exactly as in IDLE.
- Packets longer than DEPTH are always dropped.
- Read:
  - rd_vld = (pkt_cnt != 0); rd_sop, rd_eop and rd_data = mem[rptr] combinationally.
  - rd_en&rd_vld: rptr++; if the popped word has eop, pkt_cnt--.
  - rd_en with !rd_vld is ignored.
  - Uncommitted words are never visible.
- Simultaneous commit and eop-pop in one cycle: pkt_cnt unchanged.
- Latency: a packet's eop written in cycle N gives rd_vld=1 in cycle N+1.
- drop_cnt saturates at all-ones.
- overflow is cleared only by rst.
- Pointer arithmetic wraps modulo 2*DEPTH; wrap bit distinguishes full from empty.

Test Plan:
- Reset, write 4-word packet 0x10..0x13 (sop w0, eop w3): rd_vld=0 through the eop cycle, 1 the next cycle. Pop 4: data 0x10..0x13, rd_sop only on 0x10, rd_eop only on 0x13. pkt_cnt 1->0, free_cnt back to 32.
- Single-word packet, sop&eop&vld in one cycle, data 0xAB: next cycle pkt_cnt=1, rd_vld=1, rd_sop=rd_eop=1, rd_data=0xAB.
- DEPTH=32, no reads; write 20-word packet (committed), then a 16-word packet:
  - 13th word finds full: drop_cnt=1, overflow=1, pkt_cnt=1, free_cnt=12.
  - First packet then reads out intact.
  - A following 10-word packet commits.
- Wrap-around: five 24-word packets with incrementing data, each read fully before the next is written. All data correct across the pointer wrap, drop_cnt=0.
- Pop the eop word of packet A in the same cycle packet B's eop is written: pkt_cnt stays 1. Packet B is then readable.
- Write 3 words of a packet, then a new sop without eop: drop_cnt=1, overflow=0, and only the new packet is read. Separately, assert rst mid-packet: next cycle rd_vld=0, pkt_cnt=0, free_cnt=32.
